median_window_feeder: RTL and testbench
=======================================

# median_window_feeder

Turns a raster-order pixel stream into the serial 3x3 window stream consumed by MEDIAN. It is the transmit side of the MEDIAN DI/DSI/DSO protocol. For every pixel it sends its 9 neighbours (border-replicated) on WDO with WDSO framing, then waits for MEDIAN's DSO before sending the next window. Input rows are held in a 3-row circular line buffer, so the full frame is never stored.

## Interface
- WIDTH, 256, pixels per row (≥2)
- HEIGHT, 256, rows per frame (≥2)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- PIX_IN  in  8  raster pixel, row 0 first, left to right
- PIX_VALID  in  1  PIX_IN valid; held until accepted
- PIX_READY  out  1  transfer occurs when PIX_VALID & PIX_READY at a rising edge
- WDO  out  8  window pixel, to MEDIAN DI
- WDSO  out  1  window strobe, to MEDIAN DSI
- MDSO  in  1  MEDIAN DSO (median ready)
- FRAME_DONE  out  1  one-cycle pulse after last window of frame is acknowledged

## Operation
- Line buffer: 3 slots of WIDTH bytes. Input row r goes to slot r mod 3.
- Window for pixel (x,y), k=0..8: i=k/3−1, j=k%3−1, value = pix(clamp(y+i), clamp(x+j)), where clamp(−1)=0 and clamp(N)=N−1. Row-major order, top-left first.
- Window order: x increments, then y. y runs 0..HEIGHT−1.
- FSM states:
  - FILL: PIX_READY=1. Accept pixels into the buffer until the fill target is met, then go to SEND with x=0.
  - SEND: 9 cycles, WDSO=1, WDO=v[k].
  - WAIT: WDSO=0. Stay until MDSO=1 is sampled, then go to GAP.
  - GAP: 1 cycle, WDSO=0. Then:
    - x<WIDTH−1: SEND, x+1.
    - else y<HEIGHT−2: FILL, 1 row (row y+2), y+1.
    - else y=HEIGHT−2: SEND, x=0, y+1, no fill.
    - else (y=HEIGHT−1): DONE.
  - DONE: FRAME_DONE=1 for one cycle. Then FILL for a new frame, 2-row target, x=y=0.
- Fill targets:
  - Start of frame: 2 rows (2·WIDTH pixels).
  - Before rows 1..HEIGHT−2: 1 row.
  - Before row HEIGHT−1: none.
- Row y+2 overwrites slot (y−1) mod 3. That slot is dead once row y is fully sent.
- Input is accepted only in FILL. PIX_VALID gaps are tolerated: FILL waits without timeout.
- MDSO is ignored outside WAIT. No other MDSO checking.
- Counters: x, y, k, fill column and fill row. All widths are sized to their parameters, with no wrap beyond range.

## Timing
- Reset values (RST=1): state=FILL with 2-row target, all counters 0, PIX_READY=0, WDSO=0, WDO=0, FRAME_DONE=0. Buffer contents don't care.
- PIX_READY=1 from the first rising edge after RST falls.
- RST asserted mid-SEND or mid-WAIT:
  - WDSO drops immediately (asynchronously).
  - The frame is abandoned and the next pixel accepted is pixel (0,0).
- First window: WDSO rises on the edge after the 2·WIDTH-th pixel is accepted.
- WDSO is high for exactly 9 consecutive cycles per window. WDO is stable for each full cycle. WDO=0 whenever WDSO=0.
- WAIT is entered on the edge that ends SEND. MDSO may already be 1 in that first WAIT cycle.
- Window spacing: at least 1 idle cycle (GAP) after the MDSO sample before the next WDSO=1. Best case between window starts is 9 + 1 (WAIT) + 1 (GAP) = 11 cycles.
- Buffer read latency is internal and must be hidden inside the SEND timing above. Prefetch during GAP or FILL as needed.
- FRAME_DONE rises on the edge after the final GAP and lasts 1 cycle. PIX_READY returns to 1 on the following edge.

## Test plan
- **Reset:** hold RST 3 cycles → PIX_READY=0, WDSO=0, WDO=0, FRAME_DONE=0. Release → PIX_READY=1 next edge. RST pulse during the 5th SEND cycle → WDSO=0 at once, and the next window is built from freshly streamed rows.
- **Top-left corner** (WIDTH=4, HEIGHT=3, pix=16y+x, MDSO pulsed 2 cycles after WDSO falls) → window (0,0) = 0,0,1,0,0,1,16,16,17. PIX_READY drops after exactly 8 pixels.
- **Bottom-right corner** (same image) → window (3,2) = 18,19,19,34,35,35,34,35,35, with no input accepted before row 2's windows. FRAME_DONE pulses once after its MDSO; PIX_READY=1 next cycle.
- **Handshake:** hold MDSO=0 for 20 cycles after a window → WDSO stays 0 throughout. Drive MDSO=1 during SEND → no effect. Pulse MDSO in WAIT → exactly 1 GAP cycle, then WDSO=1.
- **Input stalls:** random PIX_VALID deasserts during FILL → no pixel lost or duplicated. All 12 windows of the 4x3 frame match the software clamp model.
- **System:** 256x256 noisy test image through feeder and MEDIAN → 65536 DSO results matching the software median. Then a second back-to-back frame gives identical output.

Source files
------------

// File: rtl/median_window_feeder.sv
// Raster pixel stream to serial 3x3 border-replicated windows for the MEDIAN block.
// Three row slots form a circular line buffer; each window waits for MDSO before the next.
module median_window_feeder #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] PIX_IN,
  input  logic       PIX_VALID,
  output logic       PIX_READY,
  output logic [7:0] WDO,
  output logic       WDSO,
  input  logic       MDSO,
  output logic       FRAME_DONE
);

  localparam int XW = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [XW-1:0] X1   = XW'(1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] YPEN = YW'(HEIGHT - 2);
  localparam logic [YW-1:0] Y1   = YW'(1);

  typedef enum logic [2:0] {S_FILL, S_SEND, S_WAIT, S_GAP, S_DONE} state_t;

  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [3:0]      r_k;
  logic [XW-1:0]   r_fcol;
  logic [1:0]      r_rows_left;
  logic [1:0]      r_slot_y;
  logic [1:0]      r_wslot;
  logic            r_ready;
  logic            r_wdso;
  logic [7:0]      r_wdo;
  logic            r_done;
  logic [7:0]      r_mem [3][WIDTH];

  logic [XW-1:0]   w_tx;
  logic [YW-1:0]   w_ty;
  logic [1:0]      w_tslot;
  logic [3:0]      w_tk;
  logic [1:0]      w_slot_top;
  logic [1:0]      w_slot_bot;
  logic [XW-1:0]   w_col_l;
  logic [XW-1:0]   w_col_r;
  logic [1:0]      w_rslot;
  logic [XW-1:0]   w_rcol;
  logic [7:0]      w_pix;
  logic            w_accept;

  function automatic logic [1:0] inc3(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] dec3(input logic [1:0] s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

  assign w_accept   = (r_state == S_FILL) && r_ready && PIX_VALID;
  assign PIX_READY  = r_ready;
  assign WDO        = r_wdo;
  assign WDSO       = r_wdso;
  assign FRAME_DONE = r_done;

  // The element registered onto WDO at the next edge: next k in SEND, k=0 of the next window in GAP/FILL.
  always_comb begin
    w_tx    = r_x;
    w_ty    = r_y;
    w_tslot = r_slot_y;
    w_tk    = 4'd0;
    if (r_state == S_SEND) begin
      w_tk = r_k + 4'd1;
    end else if (r_state == S_GAP) begin
      if (r_x != XMAX) begin
        w_tx = r_x + X1;
      end else begin
        w_tx = '0;
        if (r_y != YMAX) begin
          w_ty    = r_y + Y1;
          w_tslot = inc3(r_slot_y);
        end
      end
    end
    w_slot_top = (w_ty == '0)   ? w_tslot : dec3(w_tslot);
    w_slot_bot = (w_ty == YMAX) ? w_tslot : inc3(w_tslot);
    w_col_l    = (w_tx == '0)   ? w_tx : w_tx - X1;
    w_col_r    = (w_tx == XMAX) ? w_tx : w_tx + X1;
    case (w_tk)
      4'd0, 4'd1, 4'd2: w_rslot = w_slot_top;
      4'd3, 4'd4, 4'd5: w_rslot = w_tslot;
      default:          w_rslot = w_slot_bot;
    endcase
    case (w_tk)
      4'd0, 4'd3, 4'd6: w_rcol = w_col_l;
      4'd1, 4'd4, 4'd7: w_rcol = w_tx;
      default:          w_rcol = w_col_r;
    endcase
    w_pix = r_mem[w_rslot][w_rcol];
  end

  always_ff @(posedge CLK) begin
    if (w_accept) r_mem[r_wslot][r_fcol] <= PIX_IN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_FILL;
      r_x         <= '0;
      r_y         <= '0;
      r_k         <= '0;
      r_fcol      <= '0;
      r_rows_left <= 2'd2;
      r_slot_y    <= '0;
      r_wslot     <= '0;
      r_ready     <= 1'b0;
      r_wdso      <= 1'b0;
      r_wdo       <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (r_rows_left == 2'd0) begin
            r_state <= S_SEND;
            r_k     <= '0;
            r_wdso  <= 1'b1;
            r_wdo   <= w_pix;
          end else if (w_accept) begin
            if (r_fcol == XMAX) begin
              r_fcol      <= '0;
              r_wslot     <= inc3(r_wslot);
              r_rows_left <= r_rows_left - 2'd1;
              if (r_rows_left == 2'd1) r_ready <= 1'b0;
            end else begin
              r_fcol <= r_fcol + X1;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_SEND: begin
          if (r_k == 4'd8) begin
            r_state <= S_WAIT;
            r_wdso  <= 1'b0;
            r_wdo   <= '0;
          end else begin
            r_k   <= r_k + 4'd1;
            r_wdo <= w_pix;
          end
        end
        S_WAIT: begin
          if (MDSO) r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_x != XMAX) begin
            r_x     <= r_x + X1;
            r_state <= S_SEND;
            r_k     <= '0;
            r_wdso  <= 1'b1;
            r_wdo   <= w_pix;
          end else if (r_y != YMAX) begin
            r_x      <= '0;
            r_y      <= r_y + Y1;
            r_slot_y <= inc3(r_slot_y);
            // The last row already sits in the buffer, so no refill before it.
            if (r_y == YPEN) begin
              r_state <= S_SEND;
              r_k     <= '0;
              r_wdso  <= 1'b1;
              r_wdo   <= w_pix;
            end else begin
              r_state     <= S_FILL;
              r_rows_left <= 2'd1;
              r_ready     <= 1'b1;
            end
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done      <= 1'b0;
          r_state     <= S_FILL;
          r_x         <= '0;
          r_y         <= '0;
          r_slot_y    <= '0;
          r_wslot     <= '0;
          r_fcol      <= '0;
          r_rows_left <= 2'd2;
          r_ready     <= 1'b1;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Scoreboard bench for median_window_feeder on a 4x3 frame: clamp-model windows,
// randomized PIX_VALID gaps and MDSO latencies, async reset abort mid-window.
module tb_median_window_feeder;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NW = W * H;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] PIX_IN = '0;
  logic       PIX_VALID = 1'b0;
  logic       PIX_READY;
  logic [7:0] WDO;
  logic       WDSO;
  logic       MDSO = 1'b0;
  logic       FRAME_DONE;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cnt = 0, m_cyc = -100, last_fall = 0;
  int run = 0, win = 0, mon_base = 0, mon_frame = 0, done_cnt = 0;
  bit done_next = 0, ignore = 0;
  logic [7:0] exp_q[$];
  logic [7:0] img [H][W];
  int c00 [9] = '{0, 0, 1, 0, 0, 1, 16, 16, 17};
  int c32 [9] = '{18, 19, 19, 34, 35, 35, 34, 35, 35};

  median_window_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
    .CLK(CLK), .RST(RST), .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .WDO(WDO), .WDSO(WDSO), .MDSO(MDSO), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) if (PIX_VALID && PIX_READY) acc_cnt <= acc_cnt + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int clampi(input int v, input int n);
    return (v < 0) ? 0 : ((v >= n) ? n - 1 : v);
  endfunction

  task automatic load_frame(input bit ramp, input bit push);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = ramp ? 8'(16 * y + x) : 8'($urandom_range(0, 255));
    if (push)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          for (int k = 0; k < 9; k++)
            exp_q.push_back(img[clampi(y + k / 3 - 1, H)][clampi(x + k % 3 - 1, W)]);
  endtask

  task automatic drive_pix(input logic [7:0] p, input bit gaps);
    int tgt, t;
    if (gaps && $urandom_range(0, 2) == 0) begin
      PIX_VALID = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge CLK);
    end
    PIX_IN = p;
    PIX_VALID = 1'b1;
    tgt = acc_cnt + 1;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (acc_cnt != tgt && t < 5000);
    if (acc_cnt != tgt) begin
      $display("FAIL pix_accept_timeout actual=%0d required=%0d", acc_cnt, tgt);
      $fatal(1, "pixel never accepted");
    end
  endtask

  task automatic drive_rows(input int rows, input bit gaps);
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < W; x++)
        drive_pix(img[y][x], gaps);
  endtask

  task automatic wait_idle(input int frames);
    int t = 0;
    while ((exp_q.size() != 0 || done_cnt != frames) && t < 20000) begin
      @(negedge CLK);
      t++;
    end
    chk("drain_frames", done_cnt, frames);
  endtask

  // MEDIAN stand-in: acknowledges each window after 0..3 (sometimes 20) WAIT cycles, with stray pulses during SEND.
  initial begin
    int pend;
    bit prev;
    pend = -1;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        MDSO = 1'b0;
        pend = -1;
        prev = 1'b0;
      end else begin
        MDSO = 1'b0;
        if (WDSO && $urandom_range(0, 7) == 0) MDSO = 1'b1;
        if (prev && !WDSO) pend = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
        if (pend == 0) begin
          MDSO = 1'b1;
          m_cyc = cyc;
          pend = -1;
        end else if (pend > 0) begin
          pend--;
        end
        prev = WDSO;
      end
    end
  end

  // Monitor: pops expected window pixels and checks framing, spacing and input accounting.
  always @(negedge CLK) begin
    int x, y, rows;
    if (RST) begin
      run = 0;
      win = 0;
      done_next = 0;
    end else begin
      if (WDSO) begin
        if (run == 0 && !ignore) begin
          y = win / W;
          x = win % W;
          rows = (y + 2 < H) ? y + 2 : H;
          chk("accepted_at_window", acc_cnt, mon_base + W * rows);
          if (win > 0) begin
            if (x > 0 || y == H - 1) chk("gap_to_window", cyc - m_cyc, 2);
            else begin
              chk("fill_after_ack", int'(cyc - m_cyc >= 3 + W), 1);
              chk("ack_before_fill", int'(m_cyc >= last_fall), 1);
            end
          end
        end
        if (!ignore) begin
          if (exp_q.size() == 0) chk("wdo_unexpected", 1, 0);
          else chk("wdo", WDO, exp_q.pop_front());
          if (mon_frame == 0 && run < 9 && win == 0) chk("corner_tl", WDO, c00[run]);
          if (mon_frame == 0 && run < 9 && win == NW - 1) chk("corner_br", WDO, c32[run]);
        end
        run++;
      end else begin
        if (run != 0) begin
          chk("wdso_len", run, 9);
          last_fall = cyc;
          run = 0;
          win++;
          if (win == NW && !ignore) begin
            win = 0;
            mon_base += NW;
            mon_frame++;
          end
        end
        chk("wdo_idle", WDO, 0);
      end
      if (FRAME_DONE) begin
        chk("done_timing", cyc - m_cyc, 2);
        chk("done_win_count", win, 0);
        done_cnt++;
        done_next = 1;
      end else if (done_next) begin
        chk("ready_after_done", PIX_READY, 1);
        done_next = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", PIX_READY, 0);
    chk("rst_wdso", WDSO, 0);
    chk("rst_wdo", WDO, 0);
    chk("rst_done", FRAME_DONE, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", PIX_READY, 1);

    load_frame(1'b1, 1'b1);
    drive_rows(H, 1'b0);
    load_frame(1'b0, 1'b1);
    drive_rows(H, 1'b1);
    load_frame(1'b0, 1'b1);
    drive_rows(H, 1'b1);
    PIX_VALID = 1'b0;
    wait_idle(3);

    // Abort a frame during the 5th SEND cycle of its first window.
    ignore = 1;
    load_frame(1'b0, 1'b0);
    drive_rows(2, 1'b0);
    PIX_VALID = 1'b0;
    t = 0;
    do begin
      @(negedge CLK);
      #1;
      t++;
    end while (run < 5 && t < 1000);
    chk("reach_send5", int'(run >= 5), 1);
    #1;
    RST = 1'b1;
    #1;
    chk("rst_async_wdso", WDSO, 0);
    chk("rst_async_wdo", WDO, 0);
    chk("rst_async_ready", PIX_READY, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    mon_base = acc_cnt;
    ignore = 0;

    load_frame(1'b0, 1'b1);
    drive_rows(H, 1'b1);
    PIX_VALID = 1'b0;
    wait_idle(4);
    chk("queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge CLK);
    chk("idle_ready", PIX_READY, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
